clock_pattern_gen: RTL

Programmable clock-pattern generator clocked by the fast clock. It drives `clk_out` with a high time and a low time, each set in whole `clk_fst` cycles. It is the stimulus side of the high/low-time measurement path: a slow clock produced here and measured in the same `clk_fst` domain reads back exactly the programmed high/low counts. New timings are taken over a valid/ready handshake and applied only at period boundaries, so `clk_out` never carries a partial or glitched period.

---
 rtl/clkgen_pkg.sv | 6 +
 rtl/clkgen_period_cnt.sv | 22 ++
 rtl/clock_pattern_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared state encoding and constants for the clock pattern generator
package clkgen_pkg;
   localparam int CLKGEN_W = 16;
   localparam int CLKGEN_MIN_TIME = 1;
   typedef enum logic [1:0] {IDLE, HIGH, LOW} gen_state_t;
endpackage

// File: rtl/clkgen_period_cnt.sv
// clkgen_period_cnt: loadable down-counter that times one phase of the generated clock
module clkgen_period_cnt
   import clkgen_pkg::*;
#(
   parameter int W = CLKGEN_W
) (
   input  logic         clk_fst,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk_fst or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   assign cnt  = cnt_q;
   assign zero = cnt_q == '0;
endmodule

// File: rtl/clock_pattern_gen.sv
// clock_pattern_gen: programmable high/low-time clock generator with
// config updates deferred to period boundaries
module clock_pattern_gen
   import clkgen_pkg::*;
#(
   parameter int W          = CLKGEN_W,
   parameter int DEFAULT_HT = 2,
   parameter int DEFAULT_LT = 2
) (
   input  logic         clk_fst,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] ht_in,
   input  logic [W-1:0] lt_in,
   output logic         clk_out,
   output logic         period_done,
   output logic [W-1:0] ht_act,
   output logic [W-1:0] lt_act
);
   gen_state_t   state_q, state_d;
   logic [W-1:0] ht_act_q, ht_act_d, lt_act_q, lt_act_d;
   logic [W-1:0] ht_pend_q, ht_pend_d, lt_pend_q, lt_pend_d;
   logic         pend_q, pend_d, cfg_ready_q, cfg_ready_d;
   logic         clk_out_q, clk_out_d, period_done_q, period_done_d;
   logic [W-1:0] cnt, cnt_load_val, ht_cap, lt_cap;
   logic         cnt_zero, cnt_load, xfer, start, to_idle, direct, apply;

   clkgen_period_cnt #(.W(W)) u_cnt (
      .clk_fst (clk_fst),
      .reset_n (reset_n),
      .load    (cnt_load),
      .load_val(cnt_load_val),
      .dec     (state_q != IDLE),
      .cnt     (cnt),
      .zero    (cnt_zero)
   );

   always_ff @(posedge clk_fst or negedge reset_n)
      if (!reset_n) begin
         state_q       <= IDLE;
         ht_act_q      <= W'(DEFAULT_HT);
         lt_act_q      <= W'(DEFAULT_LT);
         ht_pend_q     <= '0;
         lt_pend_q     <= '0;
         pend_q        <= 1'b0;
         cfg_ready_q   <= 1'b1;
         clk_out_q     <= 1'b0;
         period_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ht_act_q      <= ht_act_d;
         lt_act_q      <= lt_act_d;
         ht_pend_q     <= ht_pend_d;
         lt_pend_q     <= lt_pend_d;
         pend_q        <= pend_d;
         cfg_ready_q   <= cfg_ready_d;
         clk_out_q     <= clk_out_d;
         period_done_q <= period_done_d;
      end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = enable ? HIGH : IDLE;
         HIGH:    state_d = cnt_zero ? LOW : HIGH;
         LOW:     state_d = cnt_zero ? (enable ? HIGH : IDLE) : LOW;
         default: state_d = IDLE;
      endcase
   end

   // A transfer lands in the active registers only when idle and not starting;
   // otherwise it waits in the pending registers for the next boundary.
   always_comb begin
      ht_cap       = (ht_in < W'(CLKGEN_MIN_TIME)) ? W'(CLKGEN_MIN_TIME) : ht_in;
      lt_cap       = (lt_in < W'(CLKGEN_MIN_TIME)) ? W'(CLKGEN_MIN_TIME) : lt_in;
      start        = state_d == HIGH && state_q != HIGH;
      to_idle      = state_d == IDLE && state_q != IDLE;
      xfer         = cfg_valid && cfg_ready_q;
      direct       = xfer && state_q == IDLE && !start;
      apply        = pend_q && (start || to_idle);
      ht_act_d     = direct ? ht_cap : apply ? ht_pend_q : ht_act_q;
      lt_act_d     = direct ? lt_cap : apply ? lt_pend_q : lt_act_q;
      ht_pend_d    = (xfer && !direct) ? ht_cap : ht_pend_q;
      lt_pend_d    = (xfer && !direct) ? lt_cap : lt_pend_q;
      pend_d       = (xfer && !direct) || (pend_q && !apply);
      cfg_ready_d  = !pend_d;
      cnt_load     = state_d != state_q && state_d != IDLE;
      cnt_load_val = (state_d == HIGH ? (apply ? ht_pend_q : ht_act_q) : lt_act_q) - W'(1);
   end

   always_comb begin
      clk_out_d     = state_d == HIGH;
      period_done_d = state_d == LOW && (cnt_load ? lt_act_q == W'(1) : cnt == W'(1));
   end

   assign clk_out     = clk_out_q;
   assign period_done = period_done_q;
   assign cfg_ready   = cfg_ready_q;
   assign ht_act      = ht_act_q;
   assign lt_act      = lt_act_q;
endmodule
